// File: rtl/cafe_order_scheduler.sv
// Coffee machine order front-end: round-robin intake of panel/remote orders into
// a small FIFO and one-at-a-time issue to the brewing FSM with refill and timeout handling.
module cafe_order_scheduler #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     req_a_i,
  input  logic [1:0]               size_a_i,
  input  logic                     req_b_i,
  input  logic [1:0]               size_b_i,
  output logic                     ack_a_o,
  output logic                     ack_b_o,
  output logic                     nack_a_o,
  output logic                     nack_b_o,
  input  logic                     machine_ready_i,
  input  logic                     reservoir_ok_i,
  output logic                     brew_start_o,
  output logic [1:0]               brew_size_o,
  input  logic                     brew_done_i,
  output logic                     refill_req_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   queue_count_o,
  output logic                     fault_o,
  input  logic                     clear_fault_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TMO_C   = CW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_REFILL = 3'd2,
    S_START  = 3'd3,
    S_BREW   = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  function automatic logic size_ok(input logic [1:0] s);
    return (s != 2'b11);
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc_s;
  logic            ack_a_q, ack_b_q, nack_a_q, nack_b_q;
  logic            brew_start_q, refill_q, busy_q, fault_q;
  logic [1:0]      brew_size_q;
  logic            pop_s, push_s, grant_a_s, grant_b_s;
  logic            block_s, flush_s, space_s, va_s, vb_s;
  logic [1:0]      push_data_s;

  assign cnt_inc_s = (cnt_q >= TMO_C) ? cnt_q : cnt_q + CW'(1);

  // Brewing FSM next state; the brew window counts from the brew_start cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_WAIT;
        else               state_d = S_IDLE;
      end
      S_WAIT: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (machine_ready_i && reservoir_ok_i) begin
          state_d = S_START;
          pop_s   = 1'b1;
        end else if (machine_ready_i) begin
          state_d = S_REFILL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_REFILL: begin
        if (reservoir_ok_i) state_d = S_WAIT;
        else                state_d = S_REFILL;
      end
      S_START: begin
        state_d = S_BREW;
        cnt_d   = CW'(1);
      end
      S_BREW: begin
        cnt_d = cnt_inc_s;
        if (brew_done_i) begin
          if (count_q != '0) state_d = S_WAIT;
          else               state_d = S_IDLE;
        end else if (cnt_inc_s >= TMO_C) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_BREW;
        end
      end
      S_FAULT: begin
        if (clear_fault_i) state_d = S_IDLE;
        else               state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Round-robin arbitration and FIFO bookkeeping; a pop frees a slot for a same-cycle push.
  always_comb begin
    grant_a_s   = 1'b0;
    grant_b_s   = 1'b0;
    flush_s     = (state_d == S_FAULT);
    block_s     = (state_q == S_FAULT) || (state_d == S_FAULT);
    va_s        = req_a_i && size_ok(size_a_i) && !block_s;
    vb_s        = req_b_i && size_ok(size_b_i) && !block_s;
    space_s     = (count_q < DEPTH_C) || pop_s;
    if (space_s) begin
      if (va_s && vb_s) begin
        if (rr_q) grant_b_s = 1'b1;
        else      grant_a_s = 1'b1;
      end else if (va_s) begin
        grant_a_s = 1'b1;
      end else if (vb_s) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
    end
    push_s      = grant_a_s || grant_b_s;
    push_data_s = grant_a_s ? size_a_i : size_b_i;
    if (grant_a_s)      rr_d = 1'b1;
    else if (grant_b_s) rr_d = 1'b0;
    else                rr_d = rr_q;
    if (flush_s) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
      wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end
  end

  // State, FIFO and registered outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      nack_a_q     <= 1'b0;
      nack_b_q     <= 1'b0;
      brew_start_q <= 1'b0;
      brew_size_q  <= 2'b00;
      refill_q     <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (push_s) mem_q[wr_ptr_q] <= push_data_s;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      ack_a_q      <= grant_a_s;
      ack_b_q      <= grant_b_s;
      nack_a_q     <= req_a_i && !grant_a_s;
      nack_b_q     <= req_b_i && !grant_b_s;
      brew_start_q <= pop_s;
      if (pop_s) brew_size_q <= mem_q[rd_ptr_q];
      refill_q     <= (state_d == S_REFILL);
      busy_q       <= (state_d != S_IDLE);
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign ack_a_o       = ack_a_q;
  assign ack_b_o       = ack_b_q;
  assign nack_a_o      = nack_a_q;
  assign nack_b_o      = nack_b_q;
  assign brew_start_o  = brew_start_q;
  assign brew_size_o   = brew_size_q;
  assign refill_req_o  = refill_q;
  assign busy_o        = busy_q;
  assign queue_count_o = count_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_cafe_order_scheduler.sv
// Directed bench for cafe_order_scheduler: a vector table for arbitration/FIFO/refill
// behaviour plus hand sequences for timeout, clear_fault and asynchronous reset.
module tb_cafe_order_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_a, req_b, machine_ready, reservoir_ok, brew_done, clear_fault;
  logic [1:0] size_a, size_b;
  logic       ack_a, ack_b, nack_a, nack_b, brew_start, refill_req, busy, fault;
  logic [1:0] brew_size;
  logic [2:0] queue_count;
  logic [12:0] obs_s;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ra;  logic [1:0] sa;  logic rb;  logic [1:0] sb;
    logic       rdy; logic ok;  logic done; logic clr;
    logic       aa;  logic na;  logic ab;   logic nb;  logic st;
    logic [1:0] sz;  logic bsy; logic rf;   logic [2:0] q; logic flt;
  } vec_t;

  vec_t vecs [16];

  cafe_order_scheduler #(.DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .clock_i(clk), .reset_n_i(reset_n),
    .req_a_i(req_a), .size_a_i(size_a), .req_b_i(req_b), .size_b_i(size_b),
    .ack_a_o(ack_a), .ack_b_o(ack_b), .nack_a_o(nack_a), .nack_b_o(nack_b),
    .machine_ready_i(machine_ready), .reservoir_ok_i(reservoir_ok),
    .brew_start_o(brew_start), .brew_size_o(brew_size), .brew_done_i(brew_done),
    .refill_req_o(refill_req), .busy_o(busy), .queue_count_o(queue_count),
    .fault_o(fault), .clear_fault_i(clear_fault)
  );

  always #5 clk = ~clk;

  assign obs_s = {ack_a, nack_a, ack_b, nack_b, brew_start, brew_size, busy, refill_req, queue_count, fault};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    // ra sa rb sb rdy ok done clr | aa na ab nb st sz bsy rf q flt
    vecs[0]  = '{1'b1,2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,3'd1,1'b0};
    vecs[1]  = '{1'b1,2'b00,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b1,1'b0,3'd2,1'b0};
    vecs[2]  = '{1'b1,2'b10,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,1'b0,3'd3,1'b0};
    vecs[3]  = '{1'b0,2'b00,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b1,1'b0,3'd4,1'b0};
    vecs[4]  = '{1'b0,2'b00,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,1'b0,3'd4,1'b0};
    vecs[5]  = '{1'b1,2'b01,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,1'b0,3'd4,1'b0};
    vecs[6]  = '{1'b0,2'b00,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,3'd4,1'b0};
    vecs[7]  = '{1'b0,2'b00,1'b0,2'b00,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,3'd4,1'b0};
    vecs[8]  = '{1'b0,2'b00,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,3'd4,1'b0};
    vecs[9]  = '{1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,3'd4,1'b0};
    vecs[10] = '{1'b0,2'b00,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,3'd4,1'b0};
    vecs[11] = '{1'b0,2'b00,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,1'b0,3'd3,1'b0};
    vecs[12] = '{1'b0,2'b00,1'b0,2'b00,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0,3'd3,1'b0};
    vecs[13] = '{1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0,3'd3,1'b0};
    vecs[14] = '{1'b0,2'b00,1'b1,2'b11,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,1'b1,1'b0,3'd3,1'b0};
    vecs[15] = '{1'b0,2'b00,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,1'b0,3'd2,1'b0};

    reset_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; size_a = 2'b00; size_b = 2'b00;
    machine_ready = 1'b0; reservoir_ok = 1'b0; brew_done = 1'b0; clear_fault = 1'b0;
    step();
    step();
    chk("reset", 16'(obs_s), 16'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      req_a = vecs[i].ra; size_a = vecs[i].sa; req_b = vecs[i].rb; size_b = vecs[i].sb;
      machine_ready = vecs[i].rdy; reservoir_ok = vecs[i].ok;
      brew_done = vecs[i].done; clear_fault = vecs[i].clr;
      step();
      chk($sformatf("vec%0d", i), 16'(obs_s),
          16'({vecs[i].aa, vecs[i].na, vecs[i].ab, vecs[i].nb, vecs[i].st, vecs[i].sz,
               vecs[i].bsy, vecs[i].rf, vecs[i].q, vecs[i].flt}));
    end

    // Timeout: brew_start was seen after the last vector; brew_done never comes.
    req_a = 1'b0; req_b = 1'b0; brew_done = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("tmo_brew%0d", n), 16'({fault, busy}), 16'b01);
    end
    step();
    chk("tmo_fault", 16'({fault, busy, queue_count, brew_size}), 16'({1'b1, 1'b1, 3'd0, 2'b10}));
    req_a = 1'b1; size_a = 2'b00; req_b = 1'b1; size_b = 2'b01;
    step();
    req_a = 1'b0; req_b = 1'b0;
    chk("fault_nack", 16'({ack_a, nack_a, ack_b, nack_b, queue_count, fault}), 16'({4'b0101, 3'd0, 1'b1}));
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("fault_clear", 16'({fault, busy, queue_count}), 16'({1'b0, 1'b0, 3'd0}));

    req_a = 1'b1; size_a = 2'b11;
    step();
    req_a = 1'b0;
    chk("invalid_empty", 16'({ack_a, nack_a, queue_count}), 16'({2'b01, 3'd0}));

    // Repeat brew with brew_done on the edge the window reaches TIMEOUT_CYC.
    req_a = 1'b1; size_a = 2'b00;
    step();
    req_a = 1'b0;
    chk("rep_ack", 16'({ack_a, queue_count}), 16'({1'b1, 3'd1}));
    step();
    chk("rep_wait", 16'({busy, brew_start}), 16'b10);
    step();
    chk("rep_start", 16'({brew_start, queue_count}), 16'({1'b1, 3'd0}));
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("rep_brew%0d", n), 16'({fault, busy}), 16'b01);
    end
    brew_done = 1'b1;
    step();
    brew_done = 1'b0;
    chk("rep_done8", 16'({fault, busy}), 16'b00);
    step();
    chk("rep_after", 16'({fault, busy}), 16'b00);

    // Asynchronous reset while brewing with two orders still queued.
    machine_ready = 1'b0;
    req_a = 1'b1; size_a = 2'b01;
    step();
    req_a = 1'b0; req_b = 1'b1; size_b = 2'b10;
    step();
    req_b = 1'b0; req_a = 1'b1; size_a = 2'b00;
    step();
    req_a = 1'b0;
    chk("ar_queued", 16'(queue_count), 16'd3);
    machine_ready = 1'b1;
    step();
    chk("ar_start", 16'({brew_start, brew_size, queue_count}), 16'({1'b1, 2'b01, 3'd2}));
    step();
    chk("ar_brew", 16'({busy, brew_start, queue_count}), 16'({1'b1, 1'b0, 3'd2}));
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_async", 16'({busy, brew_start, queue_count, fault}), 16'd0);
    step();
    step();
    reset_n = 1'b1;
    brew_done = 1'b1;
    step();
    brew_done = 1'b0;
    chk("ar_done_ignored", 16'(obs_s), 16'd0);
    step();
    step();
    chk("ar_quiet", 16'(obs_s), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
